tt_um_yoda_1999serial_subtractor: RTL and testbench

TT_UM_YODA_1999SERIAL_SUBTRACTOR -- requirements
Module: tt_um_yoda_1999serial_subtractor

---
 rtl/yoda_arith_pkg.sv | 10 +
 rtl/tt_um_yoda_1999full_subtractor.sv | 13 +
 rtl/tt_um_yoda_1999serial_subtractor.sv | 113 +++++++++++
 tb/tb_tt_um_yoda_1999serial_subtractor.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/yoda_arith_pkg.sv
// Shared constants for the yoda serial arithmetic blocks: FSM encoding and default width.
package yoda_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/tt_um_yoda_1999full_subtractor.sv
// One-bit full subtractor cell: computes a - b - bin as a difference bit plus a borrow-out.
module tt_um_yoda_1999full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/tt_um_yoda_1999serial_subtractor.sv
// Bit-serial subtractor: one bit per RUN cycle, LSB first, with the result and the
// borrow-out registered on entry to DONE.
module tt_um_yoda_1999serial_subtractor
  import yoda_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic             r_br;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_done;
  logic             r_busy;

  logic             w_d;
  logic             w_br_next;
  logic             w_last;

  tt_um_yoda_1999full_subtractor u_cell (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_br),
    .diff (w_d),
    .bout (w_br_next)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // Sequencer, operand shifters and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_br    <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_br    <= bin;
            r_cnt   <= '0;
            r_work  <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_a    <= r_a >> 1;
          r_b    <= r_b >> 1;
          r_work <= {w_d, r_work[WIDTH-1:1]};
          r_br   <= w_br_next;
          r_cnt  <= r_cnt + CW'(1);
          // The last bit goes straight into the result so DONE sees the full word.
          if (w_last) begin
            r_diff  <= {w_d, r_work[WIDTH-1:1]};
            r_bout  <= w_br_next;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_done  <= 1'b0;
            r_state <= ST_RUN;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;

endmodule

// File: tb/tb_tt_um_yoda_1999serial_subtractor.sv
// Self-checking bench for the serial subtractor: vector table, corner sequences,
// held start and a random back-to-back regression, results tracked through a scoreboard.
module tb_tt_um_yoda_1999serial_subtractor;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
  } vec_t;

  typedef struct {
    logic a;
    logic b;
    logic bin;
    logic diff;
    logic bout;
  } bit_vec_t;

  typedef struct {
    logic [7:0] diff;
    logic       bout;
  } res_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;

  logic       fa, fb, fbin, fd, fbo;

  int         total;
  int         bad;
  res_t       sb_q[$];
  logic       prev_done;
  logic [7:0] last_diff;
  logic       last_bout;
  vec_t       vecs[8];
  bit_vec_t   bvecs[8];

  tt_um_yoda_1999serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  tt_um_yoda_1999full_subtractor u_cell (
    .a    (fa),
    .b    (fb),
    .bin  (fbin),
    .diff (fd),
    .bout (fbo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse pops one expected result; done must be one cycle wide.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra_done: got done=1 expected no pending result at %0t", $time);
      end else begin
        res_t r;
        r = sb_q.pop_front();
        chk("sb_diff", 32'(diff), 32'(r.diff));
        chk("sb_bout", 32'(bout), 32'(r.bout));
      end
      chk("done_width", 32'(prev_done), 32'd0);
    end
    prev_done = done;
  end

  task automatic push_exp(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin,
                          output res_t r);
    logic [8:0] full;
    full   = {1'b0, ta} - {1'b0, tb_} - {8'd0, tbin};
    r.diff = full[7:0];
    r.bout = full[8];
    sb_q.push_back(r);
  endtask

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin,
                        input bit tog, input bit ign);
    res_t r;
    int   lat;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    a     = ta;
    b     = tb_;
    bin   = tbin;
    start = 1'b1;
    push_exp(ta, tb_, tbin, r);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_hold_diff", 32'(diff), 32'(last_diff));
      chk("run_hold_bout", 32'(bout), 32'(last_bout));
      start = (ign && (i == 2 || i == 5)) ? 1'b1 : 1'b0;
      if (tog || ign) begin
        a   = 8'($urandom());
        b   = 8'($urandom());
        bin = 1'($urandom());
      end
    end
    start = 1'b0;
    chk("latency", 32'(lat), 32'd9);
    chk("done_busy", 32'(busy), 32'd1);
    last_diff = r.diff;
    last_bout = r.bout;
    if (ign) begin
      start = 1'b1;
      a     = ~ta;
      b     = ~tb_;
      @(negedge clk);
      start = 1'b0;
      chk("ign_after_busy", 32'(busy), 32'd0);
      chk("ign_after_done", 32'(done), 32'd0);
      chk("ign_after_diff", 32'(diff), 32'(r.diff));
    end
  endtask

  initial begin
    res_t r;
    total     = 0;
    bad       = 0;
    prev_done = 1'b0;
    last_diff = 8'h00;
    last_bout = 1'b0;
    rst       = 1'b1;
    start     = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    bin       = 1'b0;

    bvecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    bvecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bvecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    bvecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bvecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    bvecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    bvecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    bvecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
    vecs[4] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0};
    vecs[5] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1};
    vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h54, 1'b0};

    for (int i = 0; i < 8; i++) begin
      fa   = bvecs[i].a;
      fb   = bvecs[i].b;
      fbin = bvecs[i].bin;
      #1;
      chk("cell_diff", 32'(fd), 32'(bvecs[i].diff));
      chk("cell_bout", 32'(fbo), 32'(bvecs[i].bout));
    end

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    rst = 1'b0;

    // Table vectors; the expected value in the table is also cross-checked by the scoreboard.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, 1'b0, (i == 3));
      chk("tbl_diff", 32'(diff), 32'(vecs[i].diff));
      chk("tbl_bout", 32'(bout), 32'(vecs[i].bout));
    end

    // Reset four cycles into RUN aborts the operation silently.
    @(negedge clk);
    a     = 8'h5A;
    b     = 8'h3C;
    bin   = 1'b1;
    start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      chk("abort_run_busy", 32'(busy), 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_bout", 32'(bout), 32'd0);
    last_diff = 8'h00;
    last_bout = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort_quiet", 32'(done), 32'd0);
    end
    run_op(8'h5A, 8'h3C, 1'b1, 1'b0, 1'b0);

    // Held start: one operation every 10 cycles.
    @(negedge clk);
    a     = 8'h21;
    b     = 8'h43;
    bin   = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 3; k++) push_exp(8'h21, 8'h43, 1'b0, r);
    for (int i = 1; i <= 29; i++) begin
      @(negedge clk);
      chk("held_done", 32'(done), 32'((i % 10) == 9));
      chk("held_busy", 32'(busy), 32'((i % 10) != 0));
    end
    @(negedge clk);
    start = 1'b0;
    chk("held_end_busy", 32'(busy), 32'd0);
    last_diff = r.diff;
    last_bout = r.bout;

    // Random back-to-back regression with operands toggling during RUN.
    for (int n = 0; n < 1000; n++) begin
      run_op(8'($urandom()), 8'($urandom()), 1'($urandom()), 1'b1, 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
